// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: bundles the request, shared-adder and response channels
// of adder_arbiter.
//   req_valid/req_a/req_b/req_ready : per-requester packed operand requests
//   add_a/add_b/add_sum             : connection to the shared adder
//   rsp_valid/rsp_ready/rsp_sum/rsp_id : tagged response channel
// slave modport is the arbiter side; master modport is the environment side.
interface adder_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int WORD    = 64,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*WORD-1:0] req_a;
  logic [NUM_REQ*WORD-1:0] req_b;
  logic [NUM_REQ-1:0]      req_ready;
  logic [WORD-1:0]         add_a;
  logic [WORD-1:0]         add_b;
  logic [WORD-1:0]         add_sum;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [WORD-1:0]         rsp_sum;
  logic [ID_W-1:0]         rsp_id;

  modport slave (
    input  req_valid, req_a, req_b, add_sum, rsp_ready,
    output req_ready, add_a, add_b, rsp_valid, rsp_sum, rsp_id
  );

  modport master (
    output req_valid, req_a, req_b, add_sum, rsp_ready,
    input  req_ready, add_a, add_b, rsp_valid, rsp_sum, rsp_id
  );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter/sequencer sharing one external
// combinational adder among NUM_REQ requesters. One transaction in flight:
// IDLE (grant) -> EXEC (adder settles on registered operands) -> RESP (hold
// response until accepted).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : adder_arbiter_if.slave (requests, shared adder, response)
module adder_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2,
  parameter int WORD    = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  adder_arbiter_if.slave bus
);

  localparam int unsigned N = NUM_REQ;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_last;
  logic [ID_W-1:0]   r_id;
  logic [WORD-1:0]   r_add_a;
  logic [WORD-1:0]   r_add_b;
  logic              r_rsp_valid;
  logic [WORD-1:0]   r_rsp_sum;
  logic [ID_W-1:0]   r_rsp_id;

  logic              w_any;
  logic [ID_W-1:0]   w_idx;
  logic [31:0]       w_scan;
  logic [NUM_REQ-1:0] w_grant;

  // Scan starts just after the last grant and wraps; first valid wins.
  always_comb begin
    w_any  = 1'b0;
    w_idx  = '0;
    w_scan = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_scan = (32'(r_last) + k) % N;
      if (!w_any && bus.req_valid[w_scan]) begin
        w_any = 1'b1;
        w_idx = ID_W'(w_scan);
      end
    end
  end

  // Grant is combinational and gated by reset so it drops immediately.
  always_comb begin
    w_grant = '0;
    if (rst_n && (r_state == S_IDLE) && w_any) begin
      w_grant[w_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= ID_W'(NUM_REQ - 1);
      r_id        <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= '0;
      r_rsp_id    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_add_a <= bus.req_a[32'(w_idx) * WORD +: WORD];
            r_add_b <= bus.req_b[32'(w_idx) * WORD +: WORD];
            r_id    <= w_idx;
            r_last  <= w_idx;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_sum   <= bus.add_sum;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.add_a     = r_add_a;
  assign bus.add_b     = r_add_b;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_sum   = r_rsp_sum;
  assign bus.rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

  localparam int NR = 3;
  localparam int W  = 64;
  localparam int IW = 2;

  logic clk;
  logic rst_n;

  adder_arbiter_if #(.NUM_REQ(NR), .WORD(W), .ID_W(IW)) bus ();

  adder_arbiter #(.NUM_REQ(NR), .ID_W(IW), .WORD(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [NR-1:0] v;
  logic [NR-1:0] keep;
  logic [W-1:0]  op_a [NR];
  logic [W-1:0]  op_b [NR];
  logic          rr;

  int errors;
  int checks;
  int model_last;

  assign bus.req_valid = v;
  assign bus.req_a     = {op_a[2], op_a[1], op_a[0]};
  assign bus.req_b     = {op_b[2], op_b[1], op_b[0]};
  assign bus.rsp_ready = rr;
  // Stand-in for the shared combinational adder.
  assign bus.add_sum   = bus.add_a + bus.add_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Round-robin rule: first valid requester after the last one granted.
  function automatic int model_pick(input logic [NR-1:0] vm, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (vm[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  // Drives one transaction from an IDLE point and reports what it observed.
  // Called 0..1 time units after a falling edge; samples after falling edges.
  task automatic run_txn(
    input  int            hold,
    output logic [NR-1:0] gnt,
    output int            waited,
    output logic          v_exec,
    output logic [W-1:0]  xa,
    output logic [W-1:0]  xb,
    output logic          v_resp,
    output logic [W-1:0]  sum,
    output logic [IW-1:0] id,
    output logic          stable,
    output logic          post_valid
  );
    int gi;
    #1;
    waited = 0;
    while (bus.req_ready == '0 && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    gnt = bus.req_ready;
    v_exec = 1'bx; xa = 'x; xb = 'x; v_resp = 1'b0; sum = 'x; id = 'x;
    stable = 1'b0; post_valid = 1'bx;
    if (gnt == '0) return;
    gi = 0;
    for (int i = NR - 1; i >= 0; i--) if (gnt[i]) gi = i;
    @(negedge clk);
    v_exec = bus.rsp_valid;
    xa = bus.add_a;
    xb = bus.add_b;
    // Accepted requester either re-presents new operands or drops valid.
    if (keep[gi]) begin
      op_a[gi] = rnd64();
      op_b[gi] = rnd64();
    end else begin
      v[gi] = 1'b0;
    end
    rr = (hold == 0);
    @(negedge clk);
    v_resp = bus.rsp_valid;
    sum    = bus.rsp_sum;
    id     = bus.rsp_id;
    stable = 1'b1;
    for (int h = 1; h < hold; h++) begin
      @(negedge clk);
      if (bus.rsp_sum !== sum || bus.rsp_id !== id || bus.req_ready !== '0 ||
          bus.rsp_valid !== 1'b1) stable = 1'b0;
    end
    rr = 1'b1;
    @(negedge clk);
    post_valid = bus.rsp_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rr = 1'b1;
    keep = '0;
    v = '1;
    for (int i = 0; i < NR; i++) begin op_a[i] = rnd64(); op_b[i] = rnd64(); end
    #3;
    checks++;
    if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: req_ready=%b rsp_valid=%b required 0/0", bus.req_ready, bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_sum !== '0 || bus.rsp_id !== '0 || bus.add_a !== '0 || bus.add_b !== '0) begin
      errors++;
      $display("FAIL reset_regs: sum=%h id=%0d add_a=%h add_b=%h required all 0",
               bus.rsp_sum, bus.rsp_id, bus.add_a, bus.add_b);
    end
    @(negedge clk); @(negedge clk);
    checks++;
    if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: req_ready=%b rsp_valid=%b required 0/0", bus.req_ready, bus.rsp_valid);
    end
    v = '0;
    rst_n = 1'b1;
    model_last = NR - 1;
  endtask

  // Shared expectation block is intentionally inline in each task below.
  task automatic test_single();
    logic [NR-1:0] g; int w; logic ve, vr, st, pv;
    logic [W-1:0] xa, xb, s; logic [IW-1:0] id;
    v = 3'b001; keep = '0;
    op_a[0] = 64'h0000_0000_0040_0000; op_b[0] = 64'd4;
    run_txn(0, g, w, ve, xa, xb, vr, s, id, st, pv);
    model_last = 0;
    checks++;
    if (g !== 3'b001 || w !== 0) begin
      errors++; $display("FAIL single_grant: req_ready=%b wait=%0d required 001 wait 0", g, w);
    end
    checks++;
    if (ve !== 1'b0 || xa !== 64'h40_0000 || xb !== 64'd4) begin
      errors++; $display("FAIL single_exec: rsp_valid=%b add_a=%h add_b=%h required 0/400000/4", ve, xa, xb);
    end
    checks++;
    if (vr !== 1'b1 || s !== 64'h0000_0000_0040_0004 || id !== 2'd0) begin
      errors++; $display("FAIL single_rsp: valid=%b sum=%h id=%0d required 1/400004/0", vr, s, id);
    end
    checks++;
    if (pv !== 1'b0) begin
      errors++; $display("FAIL single_drop: rsp_valid=%b after accept required 0", pv);
    end
  endtask

  task automatic test_wrap();
    logic [NR-1:0] g; int w; logic ve, vr, st, pv;
    logic [W-1:0] xa, xb, s; logic [IW-1:0] id;
    v = 3'b100; keep = '0;
    op_a[2] = '1; op_b[2] = 64'd2;
    run_txn(0, g, w, ve, xa, xb, vr, s, id, st, pv);
    model_last = 2;
    checks++;
    if (g !== 3'b100 || vr !== 1'b1 || s !== 64'h1 || id !== 2'd2) begin
      errors++; $display("FAIL wrap: grant=%b valid=%b sum=%h id=%0d required 100/1/1/2", g, vr, s, id);
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] g; int w; logic ve, vr, st, pv;
    logic [W-1:0] xa, xb, s; logic [IW-1:0] id;
    int order [6] = '{0, 1, 2, 0, 1, 2};
    int e; logic [W-1:0] ea, eb;
    v = '1; keep = '1;
    for (int i = 0; i < NR; i++) begin op_a[i] = rnd64(); op_b[i] = rnd64(); end
    for (int t = 0; t < 6; t++) begin
      e = model_pick(v, model_last);
      ea = op_a[e]; eb = op_b[e];
      run_txn(0, g, w, ve, xa, xb, vr, s, id, st, pv);
      model_last = e;
      checks++;
      if (g !== onehot(order[t]) || e != order[t] || w !== 0) begin
        errors++; $display("FAIL rr_grant[%0d]: req_ready=%b wait=%0d required %b wait 0", t, g, w, onehot(order[t]));
      end
      checks++;
      if (xa !== ea || xb !== eb || ve !== 1'b0) begin
        errors++; $display("FAIL rr_exec[%0d]: add_a=%h add_b=%h required %h %h", t, xa, xb, ea, eb);
      end
      checks++;
      if (vr !== 1'b1 || s !== ea + eb || id !== IW'(order[t])) begin
        errors++; $display("FAIL rr_rsp[%0d]: sum=%h id=%0d required %h id %0d", t, s, id, ea + eb, order[t]);
      end
    end
    v = '0;
  endtask

  task automatic test_priority_rotation();
    logic [NR-1:0] g; int w; logic ve, vr, st, pv;
    logic [W-1:0] xa, xb, s; logic [IW-1:0] id;
    int exp_seq [3] = '{2, 0, 1};
    keep = '0;
    for (int i = 0; i < NR; i++) begin op_a[i] = rnd64(); op_b[i] = rnd64(); end
    for (int t = 0; t < 3; t++) begin
      if (t == 0) v = 3'b100;
      else if (t == 1) v = 3'b011;
      run_txn(0, g, w, ve, xa, xb, vr, s, id, st, pv);
      checks++;
      if (g !== onehot(exp_seq[t]) || id !== IW'(exp_seq[t])) begin
        errors++; $display("FAIL prio_rot[%0d]: grant=%b id=%0d required %b id %0d", t, g, id, onehot(exp_seq[t]), exp_seq[t]);
      end
    end
    model_last = 1;
  endtask

  task automatic test_backpressure();
    logic [NR-1:0] g; int w; logic ve, vr, st, pv;
    logic [W-1:0] xa, xb, s; logic [IW-1:0] id;
    logic [W-1:0] a0, b0, a1, b1;
    keep = '0;
    op_a[0] = rnd64(); op_b[0] = rnd64(); op_a[1] = rnd64(); op_b[1] = rnd64();
    a0 = op_a[0]; b0 = op_b[0]; a1 = op_a[1]; b1 = op_b[1];
    v = 3'b011;
    run_txn(5, g, w, ve, xa, xb, vr, s, id, st, pv);
    checks++;
    if (g !== 3'b001 || s !== a0 + b0 || id !== 2'd0) begin
      errors++; $display("FAIL bp_first: grant=%b sum=%h id=%0d required 001 %h 0", g, s, id, a0 + b0);
    end
    checks++;
    if (st !== 1'b1) begin
      errors++; $display("FAIL bp_stable: stable=%b required 1 (sum/id held, req_ready 0)", st);
    end
    checks++;
    if (pv !== 1'b0) begin
      errors++; $display("FAIL bp_release: rsp_valid=%b after accept required 0", pv);
    end
    run_txn(0, g, w, ve, xa, xb, vr, s, id, st, pv);
    model_last = 1;
    checks++;
    if (g !== 3'b010 || w !== 0 || s !== a1 + b1 || id !== 2'd1) begin
      errors++; $display("FAIL bp_next: grant=%b wait=%0d sum=%h id=%0d required 010 0 %h 1", g, w, s, id, a1 + b1);
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] g; int w; logic ve, vr, st, pv;
    logic [W-1:0] xa, xb, s; logic [IW-1:0] id;
    int e; int hold; logic [W-1:0] ea, eb;
    for (int i = 0; i < NR; i++) begin op_a[i] = rnd64(); op_b[i] = rnd64(); end
    for (int t = 0; t < 12; t++) begin
      // Newly raised requests get fresh operands; pending ones stay stable.
      for (int i = 0; i < NR; i++) begin
        if (!v[i] && $urandom_range(1, 0) == 1) begin
          v[i] = 1'b1; op_a[i] = rnd64(); op_b[i] = rnd64();
        end
      end
      if (v == '0) v[$urandom_range(NR - 1, 0)] = 1'b1;
      keep = NR'($urandom_range(7, 0));
      if (t == 5) begin op_a[0] = '1; op_a[1] = '1; op_a[2] = '1; end
      hold = $urandom_range(2, 0);
      e = model_pick(v, model_last);
      ea = op_a[e]; eb = op_b[e];
      run_txn(hold, g, w, ve, xa, xb, vr, s, id, st, pv);
      model_last = e;
      checks++;
      if (g !== onehot(e) || vr !== 1'b1 || s !== ea + eb || id !== IW'(e) || st !== 1'b1) begin
        errors++; $display("FAIL rand[%0d]: grant=%b sum=%h id=%0d stable=%b required %b %h %0d 1",
                           t, g, s, id, st, onehot(e), ea + eb, e);
      end
    end
    v = '0;
  endtask

  task automatic test_reset_mid_op();
    logic [NR-1:0] g; int w; logic ve, vr, st, pv;
    logic [W-1:0] xa, xb, s; logic [IW-1:0] id;
    logic [W-1:0] ea, eb; int cnt; logic seen;
    keep = '0;
    op_a[1] = rnd64(); op_b[1] = rnd64();
    v = 3'b010;
    #1;
    cnt = 0;
    while (bus.req_ready == '0 && cnt < 20) begin @(negedge clk); #1; cnt++; end
    checks++;
    if (bus.req_ready !== 3'b010) begin
      errors++; $display("FAIL rstmid_grant: req_ready=%b required 010", bus.req_ready);
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.add_a !== '0 || bus.add_b !== '0 || bus.req_ready !== '0) begin
      errors++; $display("FAIL rstmid_async: rsp_valid=%b add_a=%h add_b=%h req_ready=%b required all 0",
                         bus.rsp_valid, bus.add_a, bus.add_b, bus.req_ready);
    end
    v = '1;
    for (int i = 0; i < NR; i++) begin op_a[i] = rnd64(); op_b[i] = rnd64(); end
    ea = op_a[0]; eb = op_b[0];
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== '0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rstmid_hold: response or grant seen during reset=%b required 0", seen);
    end
    rst_n = 1'b1;
    model_last = NR - 1;
    run_txn(0, g, w, ve, xa, xb, vr, s, id, st, pv);
    model_last = 0;
    checks++;
    if (g !== 3'b001 || w !== 0 || ve !== 1'b0 || vr !== 1'b1 || s !== ea + eb || id !== 2'd0) begin
      errors++; $display("FAIL rstmid_after: grant=%b wait=%0d exec_valid=%b sum=%h id=%0d required 001 0 0 %h 0",
                         g, w, ve, s, id, ea + eb);
    end
    v = '0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_last = NR - 1;
    rr = 1'b1;
    v = '0;
    keep = '0;
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_priority_rotation();
    test_backpressure();
    test_random();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
